// File: rtl/regfile_seq_ctrl.sv
// Multi-cycle sequencer for a 2-entry register file and ALU: accept, read, execute,
// optional write-back, done. One instruction in flight at a time.
module regfile_seq_ctrl #(
    parameter int DATA_W       = 5,
    parameter int ADDR_W       = 1,
    parameter int EXEC_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [ADDR_W-1:0] instr_rs,
    input  logic [ADDR_W-1:0] instr_rd,
    input  logic              instr_wen,
    output logic [ADDR_W-1:0] rf_read_reg,
    output logic [ADDR_W-1:0] rf_write_reg,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_reg_write,
    input  logic [DATA_W-1:0] rf_rd1,
    input  logic [DATA_W-1:0] rf_rd2,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_start,
    input  logic              alu_done,
    input  logic [DATA_W-1:0] alu_result,
    output logic              busy,
    output logic              timeout_err,
    output logic [7:0]        instr_count
);

    typedef enum logic [2:0] {IDLE, READ, EXEC, WB, DONE} state_t;

    // Last EXEC cycle index before giving up on alu_done.
    localparam logic [7:0] WAIT_LAST = 8'(EXEC_TIMEOUT - 1);

    state_t     state;
    logic       wen_q;
    logic [7:0] wait_cnt;

    assign instr_ready = (state == IDLE);
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            wen_q         <= 1'b0;
            wait_cnt      <= '0;
            rf_read_reg   <= '0;
            rf_write_reg  <= '0;
            rf_write_data <= '0;
            rf_reg_write  <= 1'b0;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_start     <= 1'b0;
            timeout_err   <= 1'b0;
            instr_count   <= '0;
        end else begin
            alu_start    <= 1'b0;
            rf_reg_write <= 1'b0;
            case (state)
                IDLE: begin
                    // The index outputs double as the latched rs/rd of the instruction.
                    if (instr_valid) begin
                        rf_read_reg  <= instr_rs;
                        rf_write_reg <= instr_rd;
                        wen_q        <= instr_wen;
                        state        <= READ;
                    end
                end
                READ: begin
                    alu_a     <= rf_rd1;
                    alu_b     <= rf_rd2;
                    alu_start <= 1'b1;
                    wait_cnt  <= '0;
                    state     <= EXEC;
                end
                EXEC: begin
                    // A done on the final wait cycle still completes normally.
                    if (alu_done) begin
                        rf_write_data <= alu_result;
                        if (wen_q) begin
                            rf_reg_write <= 1'b1;
                            state        <= WB;
                        end else begin
                            state <= DONE;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                WB: begin
                    state <= DONE;
                end
                DONE: begin
                    instr_count <= instr_count + 8'd1;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// Bench for regfile_seq_ctrl: register-file and ALU stand-ins, a timeline model
// checked every cycle, and directed instructions with hand-worked results.
module tb_regfile_seq_ctrl;
    localparam int DATA_W = 5;
    localparam int ADDR_W = 1;
    localparam int TO     = 15;
    localparam int NEVER  = 1000000;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              instr_valid = 1'b0;
    logic              instr_ready;
    logic [ADDR_W-1:0] instr_rs = '0;
    logic [ADDR_W-1:0] instr_rd = '0;
    logic              instr_wen = 1'b0;
    logic [ADDR_W-1:0] rf_read_reg, rf_write_reg;
    logic [DATA_W-1:0] rf_write_data;
    logic              rf_reg_write;
    logic [DATA_W-1:0] rf_rd1, rf_rd2, alu_a, alu_b;
    logic              alu_start;
    logic              alu_done = 1'b0;
    logic [DATA_W-1:0] alu_result = '0;
    logic              busy, timeout_err;
    logic [7:0]        instr_count;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    regfile_seq_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .EXEC_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_rs(instr_rs), .instr_rd(instr_rd), .instr_wen(instr_wen),
        .rf_read_reg(rf_read_reg), .rf_write_reg(rf_write_reg),
        .rf_write_data(rf_write_data), .rf_reg_write(rf_reg_write),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .alu_a(alu_a), .alu_b(alu_b), .alu_start(alu_start),
        .alu_done(alu_done), .alu_result(alu_result),
        .busy(busy), .timeout_err(timeout_err), .instr_count(instr_count)
    );

    // Register file stand-in: combinational reads, write on strobe, bench preload.
    logic [DATA_W-1:0] rf [2];
    logic              rf_load = 1'b0;
    logic [DATA_W-1:0] ld0 = '0, ld1 = '0;
    assign rf_rd1 = rf[rf_write_reg];
    assign rf_rd2 = rf[rf_read_reg];
    always @(posedge clk) begin
        if (rf_load) begin
            rf[0] <= ld0;
            rf[1] <= ld1;
        end else if (rf_reg_write) begin
            rf[rf_write_reg] <= rf_write_data;
        end
    end

    // ALU stand-in: adds, raises done alu_delay cycles after the start cycle.
    int   alu_k = -1;
    int   alu_delay = NEVER;
    logic stray_done = 1'b0;
    always @(posedge clk) begin
        #1;
        if (alu_start) alu_k = 0;
        else if (alu_k >= 0) alu_k++;
        alu_done = stray_done || (alu_k >= 0 && alu_k == alu_delay);
        if (alu_k == alu_delay) alu_k = -1;
        alu_result = alu_a + alu_b;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: expected outputs derived from each instruction's accept cycle and finish cycle.
    logic              e_ready = 1'b1, e_busy = 1'b0, e_start = 1'b0, e_write = 1'b0, e_terr = 1'b0;
    logic [ADDR_W-1:0] e_rrs = '0, e_rrd = '0;
    logic [DATA_W-1:0] e_wdata = '0, e_a = '0, e_b = '0;
    logic [7:0]        e_cnt = '0;
    logic [DATA_W-1:0] mR [2];
    bit                in_flight = 0, fin = 0, tdone = 0, m_wen = 0;
    int                ta = 0, tend = 0;
    logic [ADDR_W-1:0] m_rs = '0, m_rd = '0;
    int n_start = 0, n_write = 0, t_start = -1, t_write = -1, t_terr = -1;

    always @(negedge clk) begin
        if (reset) begin
            in_flight = 0; fin = 0;
            e_ready = 1'b1; e_busy = 1'b0; e_start = 1'b0; e_write = 1'b0; e_terr = 1'b0;
            e_rrs = '0; e_rrd = '0; e_wdata = '0; e_a = '0; e_b = '0; e_cnt = '0;
            t_terr = -1;
        end
        chk("instr_ready", instr_ready, e_ready);
        chk("busy", busy, e_busy);
        chk("alu_start", alu_start, e_start);
        chk("rf_reg_write", rf_reg_write, e_write);
        chk("timeout_err", timeout_err, e_terr);
        chk("instr_count", instr_count, e_cnt);
        chk("rf_read_reg", rf_read_reg, e_rrs);
        chk("rf_write_reg", rf_write_reg, e_rrd);
        chk("alu_a", alu_a, e_a);
        chk("alu_b", alu_b, e_b);
        chk("rf_write_data", rf_write_data, e_wdata);
        if (alu_start) begin n_start++; t_start = cyc; end
        if (rf_reg_write) begin n_write++; t_write = cyc; end
        if (timeout_err && t_terr < 0) t_terr = cyc;
        if (!reset) begin
            if (in_flight && cyc == ta + 1) begin
                e_a = mR[m_rd];
                e_b = mR[m_rs];
            end
            e_start = in_flight && (cyc == ta + 1);
            if (e_write) mR[m_rd] = e_wdata;
            if (rf_load) begin mR[0] = ld0; mR[1] = ld1; end
            e_write = 1'b0;
            if (!in_flight) begin
                if (instr_valid) begin
                    in_flight = 1; fin = 0; ta = cyc;
                    m_rs = instr_rs; m_rd = instr_rd; m_wen = instr_wen;
                    e_rrs = instr_rs; e_rrd = instr_rd;
                end
            end else begin
                if (!fin && cyc >= ta + 2) begin
                    if (alu_done) begin
                        fin = 1; tend = cyc; tdone = 1;
                        e_wdata = alu_result; e_write = m_wen;
                    end else if (cyc - (ta + 2) == TO - 1) begin
                        fin = 1; tend = cyc; tdone = 0; e_terr = 1'b1;
                    end
                end
                if (fin && cyc + 1 == tend + ((tdone && m_wen) ? 3 : 2)) begin
                    in_flight = 0;
                    e_cnt++;
                end
            end
            e_ready = !in_flight;
            e_busy  = in_flight;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        bit seen = 0;
        while (!seen && n < lim) begin
            @(negedge clk);
            if (instr_ready) seen = 1;
            n++;
        end
        if (!seen) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", lim);
        end
        tick();
    endtask

    task automatic issue(input logic rs, input logic rd, input logic wen, input int dly, output int acc);
        alu_delay = dly;
        instr_rs = rs; instr_rd = rd; instr_wen = wen; instr_valid = 1'b1;
        acc = cyc;
        tick();
        instr_valid = 1'b0;
        wait_idle(40);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int acc, s0, w0, acc_n, lim;
        repeat (2) tick();
        chk("rst_ready", instr_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_write", rf_reg_write, 0);
        chk("rst_count", instr_count, 0);
        chk("rst_terr", timeout_err, 0);
        reset = 1'b0;
        tick();
        ld0 = 5'd7; ld1 = 5'd5; rf_load = 1'b1;
        tick();
        rf_load = 1'b0;
        tick();

        // R0=7, R1=5: A=R1, B=R0, ALU adds to 12, written to R1.
        s0 = n_start; w0 = n_write;
        issue(1'b0, 1'b1, 1'b1, 1, acc);
        chk("t2_start_cycle", t_start, acc + 2);
        chk("t2_write_cycle", t_write, acc + 4);
        chk("t2_alu_a", alu_a, 5);
        chk("t2_alu_b", alu_b, 7);
        chk("t2_wdata", rf_write_data, 12);
        chk("t2_rf1", rf[1], 12);
        chk("t2_starts", n_start - s0, 1);
        chk("t2_writes", n_write - w0, 1);
        chk("t2_count", instr_count, 1);

        // Stray done while idle, then wen=0: 12+7=19 latched but not written.
        @(posedge clk); stray_done = 1'b1;
        @(posedge clk); stray_done = 1'b0;
        #1;
        tick();
        chk("t3_idle_count", instr_count, 1);
        w0 = n_write;
        issue(1'b0, 1'b1, 1'b0, 1, acc);
        chk("t3_writes", n_write - w0, 0);
        chk("t3_wdata", rf_write_data, 19);
        chk("t3_rf1", rf[1], 12);
        chk("t3_count", instr_count, 2);

        // rs==rd, done in the start cycle: write on the 4th cycle, 12+12=24.
        issue(1'b1, 1'b1, 1'b1, 0, acc);
        chk("t4_write_cycle", t_write, acc + 3);
        chk("t4_alu_a", alu_a, 12);
        chk("t4_alu_b", alu_b, 12);
        chk("t4_rf1", rf[1], 24);
        chk("t4_count", instr_count, 3);

        // Done on the last allowed EXEC cycle: completes, 7+7=14 into R0.
        issue(1'b0, 1'b0, 1'b1, TO - 1, acc);
        chk("t5_write_cycle", t_write, acc + 17);
        chk("t5_terr", timeout_err, 0);
        chk("t5_rf0", rf[0], 14);
        chk("t5_count", instr_count, 4);

        // No done: timeout after 15 EXEC cycles, no write, still counted.
        w0 = n_write;
        issue(1'b1, 1'b0, 1'b1, NEVER, acc);
        chk("t6_terr", timeout_err, 1);
        chk("t6_terr_delay", t_terr - t_start, 15);
        chk("t6_writes", n_write - w0, 0);
        chk("t6_rf0", rf[0], 14);
        chk("t6_count", instr_count, 5);
        // Next instruction after a timeout: 24+14=38 -> 6 in 5 bits; error stays set.
        issue(1'b0, 1'b1, 1'b1, 0, acc);
        chk("t6_next_rf1", rf[1], 6);
        chk("t6_next_count", instr_count, 6);
        chk("t6_sticky", timeout_err, 1);

        // Reset, then valid held through two instructions.
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("t7_terr_clr", timeout_err, 0);
        chk("t7_count_clr", instr_count, 0);
        s0 = n_start; w0 = n_write; acc_n = 0; lim = 0;
        alu_delay = 1;
        instr_rs = 1'b0; instr_rd = 1'b1; instr_wen = 1'b1; instr_valid = 1'b1;
        while (acc_n < 2 && lim < 60) begin
            @(negedge clk);
            if (instr_ready) acc_n++;
            lim++;
        end
        tick();
        instr_valid = 1'b0;
        chk("t7_accepts", acc_n, 2);
        wait_idle(40);
        chk("t7_starts", n_start - s0, 2);
        chk("t7_writes", n_write - w0, 2);
        chk("t7_count", instr_count, 2);
        chk("t7_rf1", rf[1], 2);   // 6+14=20, then 20+14=34 -> 2

        // Reset during EXEC: immediate return to reset values, no write strobe.
        alu_delay = NEVER;
        instr_rs = 1'b0; instr_rd = 1'b1; instr_wen = 1'b1; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        repeat (4) tick();
        chk("t8_in_exec", busy, 1);
        w0 = n_write;
        reset = 1'b1;
        #1;
        chk("t8_busy", busy, 0);
        chk("t8_ready", instr_ready, 1);
        chk("t8_count", instr_count, 0);
        chk("t8_alu_a", alu_a, 0);
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("t8_writes", n_write - w0, 0);
        issue(1'b0, 1'b1, 1'b1, 1, acc);
        chk("t8_after_rf1", rf[1], 16);   // 2+14
        chk("t8_after_count", instr_count, 1);
        chk("t8_after_writes", n_write - w0, 1);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_seq_ctrl.md
Name: regfile_seq_ctrl

Overview:
Multi-cycle sequencer that drives the 2-entry, 5-bit register file and the ALU for one instruction at a time.
- Accepts a decoded instruction over a valid/ready handshake.
- Sequences register read, ALU execute and write-back, then returns to idle.
- Sits between the instruction decode stage and the register file / ALU pair, and is the only source of register-file read/write control.

Parameters:
DATA_W, 5, register and ALU data width
ADDR_W, 1, register index width (2 registers)
EXEC_TIMEOUT, 15, max cycles to wait for alu_done before aborting (1..255)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
instr_valid  input  1  decoded instruction available
instr_ready  output  1  controller can accept instruction
instr_rs  input  ADDR_W  source register index
instr_rd  input  ADDR_W  destination register index (also second operand)
instr_wen  input  1  instruction writes result back
rf_read_reg  output  ADDR_W  register file read index
rf_write_reg  output  ADDR_W  register file write index
rf_write_data  output  DATA_W  register file write data
rf_reg_write  output  1  register file write strobe, one cycle
rf_rd1  input  DATA_W  read data at rf_write_reg
rf_rd2  input  DATA_W  read data at rf_read_reg
alu_a  output  DATA_W  ALU operand A
alu_b  output  DATA_W  ALU operand B
alu_start  output  1  one-cycle ALU start pulse
alu_done  input  1  ALU result valid
alu_result  input  DATA_W  ALU result
busy  output  1  instruction in flight
timeout_err  output  1  sticky, ALU timeout occurred
instr_count  output  8  completed instructions, wraps 255->0

Behaviour:
- Reset (async, active-high), all outputs 0 except instr_ready=1:
  - state=IDLE; rf_reg_write=0, alu_start=0, busy=0, timeout_err=0, instr_count=0.
  - Index/data/operand registers = 0.
- Reset asserted mid-instruction:
  - Aborts immediately; no write strobe is issued.
  - Latched instruction is discarded.
- States:
  - IDLE:
    - instr_ready=1.
    - On instr_valid&&instr_ready: latch rs, rd, wen; drive rf_read_reg=rs and rf_write_reg=rd; go READ.
  - READ (1 cycle):
    - Register file reads are combinational; sample rf_rd1 into alu_a and rf_rd2 into alu_b at the end of this cycle.
    - Go EXEC; alu_start=1 during the first EXEC cycle only.
  - EXEC:
    - Wait counter starts at 0 and increments each cycle.
    - alu_done=1: latch alu_result into rf_write_data. Go WB if wen=1, else DONE.
    - Counter reaches EXEC_TIMEOUT with no alu_done: set timeout_err, go DONE (no write).
    - alu_done on the same cycle as the timeout: alu_done wins.
  - WB (1 cycle):
    - rf_reg_write=1 with rf_write_reg=rd and rf_write_data stable.
    - Go DONE.
  - DONE (1 cycle):
    - instr_count increments, including timed-out instructions.
    - Go IDLE.
- busy=1 in every state except IDLE; instr_ready = (state==IDLE).
- Minimum latency, accept to write strobe: accept cycle, READ, EXEC(done same cycle), WB = write on 4th cycle. Next accept 2 cycles after WB.
- alu_done outside EXEC is ignored.
- instr_valid while busy is not accepted; the upstream stage holds it.
- rf_read_reg and rf_write_reg hold their latched values from accept until the next accept.
- rs==rd is legal; both operands equal that register.
- timeout_err clears only on reset.
- All outputs are registered, except instr_ready and busy, which decode from the state register.

Test Plan:
- Reset then idle → instr_ready=1, busy=0, rf_reg_write=0, instr_count=0, timeout_err=0.
- Accept rs=0, rd=1, wen=1; regs R0=7, R1=5; ALU returns 12 one cycle after start → alu_a=5, alu_b=7, single alu_start pulse, rf_reg_write=1 for one cycle with rf_write_reg=1 and data=12; instr_count=1.
- Same instruction with wen=0 → no rf_reg_write pulse; instr_count increments; instr_ready returns after DONE.
- alu_done never asserted → after 15 EXEC cycles timeout_err=1, no write, instr_count increments, controller accepts the next instruction.
- instr_valid held high through two instructions → second accepted only in IDLE; exactly one start and one write per instruction; instr_count=2.
- Reset asserted during EXEC → outputs return to reset values immediately; no write strobe seen. A new instruction after reset release completes normally.
